// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEPTH_MAX = 4;
  localparam int unsigned CNT_W     = $clog2(DEPTH_MAX + 1);

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  function automatic master_id_t other_master(master_id_t id);
    return (id == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/dmem_arb_owner_fifo.sv
// Records which master owns each outstanding slave transfer, in issue order.
module dmem_arb_owner_fifo
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << PTR_W;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             mem [SLOTS];
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: head is only consumed when the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one RAM slave between the core data port (m0)
// and DMA (m1), with in-order response routing via an owner FIFO.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req,
  input  logic [AW-1:0]   m0_addr,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_be,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_err,
  input  logic            m1_req,
  input  logic [AW-1:0]   m1_addr,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_be,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_err,
  output logic            s_req,
  output logic [AW-1:0]   s_addr,
  output logic            s_we,
  output logic [DW/8-1:0] s_be,
  output logic [DW-1:0]   s_wdata,
  input  logic            s_gnt,
  input  logic            s_rvalid,
  input  logic [DW-1:0]   s_rdata,
  input  logic            s_err,
  output logic            protocol_err
);

  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_depth_check
    $error("dmem_arbiter: DEPTH must be in 1..%0d", DEPTH_MAX);
  end

  master_id_t       prio;
  master_id_t       sel;
  logic             accept;
  logic             pop;
  logic             fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // Priority pointer only breaks ties; a lone requester always wins.
  always_comb begin
    sel = M0;
    if (m0_req && m1_req) sel = prio;
    else if (m1_req)      sel = M1;
  end

  // No full-bypass: a pop in the same cycle does not reopen the slot.
  assign s_req  = rst_n & (m0_req | m1_req) & ~fifo_full;
  assign accept = s_req & s_gnt;
  assign m0_gnt = accept & (sel == M0);
  assign m1_gnt = accept & (sel == M1);

  always_comb begin
    if (sel == M1) begin
      s_addr  = m1_addr;
      s_we    = m1_we;
      s_be    = m1_be;
      s_wdata = m1_wdata;
    end else begin
      s_addr  = m0_addr;
      s_we    = m0_we;
      s_be    = m0_be;
      s_wdata = m0_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio <= M0;
    else if (accept) prio <= other_master(sel);
  end

  dmem_arb_owner_fifo #(
    .DEPTH (DEPTH)
  ) u_owner_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .push_id (sel),
    .pop     (pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Responses are routed to the oldest owner; strays with nothing outstanding are dropped.
  assign pop       = s_rvalid & ~fifo_empty;
  assign m0_rvalid = pop & (fifo_head == M0);
  assign m1_rvalid = pop & (fifo_head == M1);
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m0_err    = s_err;
  assign m1_err    = s_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      protocol_err <= 1'b0;
    else if (s_rvalid && fifo_empty) protocol_err <= 1'b1;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CNT_W'(DEPTH));

endmodule
